// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Converts a binary value to packed BCD with a sequential double-dabble,
// then time-multiplexes the digits onto one BCD nibble for a shared
// 7-segment decoder, driving the matching active-low digit enable.
// Handles leading-zero blanking and overflow saturation (all nines).
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   binIn     unsigned value to display
//   load      single-cycle request to convert binIn (ignored while busy)
//   blankEn   1 = blank leading zeros (sampled live)
//   BCDout    digit value to the shared decoder, always 0-9
//   digitSel  active-low one-hot digit enable (all ones when blanked)
//   busy      conversion in progress
//   ovf       last committed value exceeded 10^NUM_DIGITS-1
module seg_scan_controller #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_W      = 14,
   parameter int unsigned SCAN_DIV   = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      binIn,
   input  logic                  load,
   input  logic                  blankEn,
   output logic [3:0]            BCDout,
   output logic [NUM_DIGITS-1:0] digitSel,
   output logic                  busy,
   output logic                  ovf
);

   localparam int unsigned ACC_W = NUM_DIGITS * 4;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   // Largest displayable value, 10^NUM_DIGITS - 1
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

   // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
   // Carry out of the top nibble is dropped; the overflow path covers it.
   function automatic logic [ACC_W+BIN_W-1:0] dabble(
      input logic [ACC_W-1:0] bcd,
      input logic [BIN_W-1:0] bin
   );
      logic [ACC_W-1:0] adj;
      adj = bcd;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (adj[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
         end
      end
      return {adj, bin} << 1;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_COMMIT
   } state_e;

   state_e state_q, state_d;

   logic [BIN_W-1:0]            bin_q, bin_d;
   logic [ACC_W-1:0]            bcd_q, bcd_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        ovf_pend_q, ovf_pend_d;
   logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
   logic                        ovf_q, ovf_d;
   logic                        busy_q, busy_d;
   logic [ACC_W+BIN_W-1:0]      step;

   logic [PRE_W-1:0]            pre_q, pre_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [3:0]                  nib_q, nib_d;
   logic [NUM_DIGITS-1:0]       sel_q, sel_d;
   logic [NUM_DIGITS-1:0]       zero_from;
   logic                        blank_c;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Conversion datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         disp_q     <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         disp_q     <= disp_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state and conversion datapath
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      disp_d     = disp_q;
      ovf_d      = ovf_q;
      step       = dabble(bcd_q, bin_q);

      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d      = binIn;
               bcd_d      = '0;
               cnt_d      = '0;
               ovf_pend_d = (64'(binIn) > MAX_VAL);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {bcd_d, bin_d} = step;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = S_COMMIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_COMMIT: begin
            // Display only ever sees a finished (or saturated) value
            disp_d  = ovf_pend_q ? {NUM_DIGITS{4'h9}} : bcd_q;
            ovf_d   = ovf_pend_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Scan prescaler and digit index, free-running regardless of FSM state
   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         idx_q <= '0;
      end else begin
         pre_q <= pre_d;
         idx_q <= idx_d;
      end
   end

   // Blanking: zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero
   always_comb begin
      zero_from                 = '0;
      zero_from[NUM_DIGITS-1]   = (disp_q[NUM_DIGITS-1] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (disp_q[i] == 4'd0);
      end
      blank_c = blankEn && (idx_q != '0) && zero_from[idx_q];
      nib_d   = disp_q[idx_q];
      sel_d   = blank_c ? '1 : ~(NUM_DIGITS'(1) << idx_q);
   end

   // Registered scan outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         nib_q <= '0;
         sel_q <= ~NUM_DIGITS'(1);
      end else begin
         nib_q <= nib_d;
         sel_q <= sel_d;
      end
   end

   assign BCDout   = nib_q;
   assign digitSel = sel_q;
   assign busy     = busy_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller
// Scoreboard bench: stimulus pushes expected commits into a queue, a monitor
// pops them when busy falls and checks the scanned digits every cycle
// against a decimal model of the displayed value.
module tb_seg_scan_controller;

   localparam int N  = 4;
   localparam int BW = 14;
   localparam int S  = 4;

   typedef struct {
      int val;
      bit ovf;
      int commit_k;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] binIn = '0;
   logic          load = 1'b0;
   logic          blankEn = 1'b0;
   logic [3:0]    BCDout;
   logic [N-1:0]  digitSel;
   logic          busy;
   logic          ovf;

   exp_t sb[$];
   int   k = 0;
   bit   rst_e = 1'b1;
   bit   blank_e = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   next_ok = 0;
   int   disp_m = 0;
   bit   ovf_m = 1'b0;
   bit   busy_prev = 1'b0;
   int   busy_cnt = 0;

   seg_scan_controller #(
      .NUM_DIGITS(N),
      .BIN_W     (BW),
      .SCAN_DIV  (S)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .binIn   (binIn),
      .load    (load),
      .blankEn (blankEn),
      .BCDout  (BCDout),
      .digitSel(digitSel),
      .busy    (busy),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   function automatic int p10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", nm, act, exp_v, k, $time);
      end
   endtask

   // Edge bookkeeping: inputs as the DUT saw them, and edges since reset release
   always @(posedge clk) begin
      rst_e   = rst;
      blank_e = blankEn;
      if (rst) k = 0;
      else     k = k + 1;
   end

   // Monitor
   always @(negedge clk) begin : mon
      int          idx;
      int          dig;
      bit          blanked;
      logic [N-1:0] esel;
      bit          have_new;
      int          new_disp;
      exp_t        it;
      have_new = 1'b0;
      new_disp = 0;
      if (rst_e) begin
         chk("rst_BCDout", BCDout, 0);
         chk("rst_digitSel", digitSel, 4'b1110);
         chk("rst_busy", busy, 0);
         chk("rst_ovf", ovf, 0);
         sb.delete();
         disp_m    = 0;
         ovf_m     = 1'b0;
         busy_prev = 1'b0;
         busy_cnt  = 0;
      end else begin
         if (busy) busy_cnt++;
         if (busy_prev && !busy) begin
            if (sb.size() == 0) begin
               chk("spurious_commit", 1, 0);
            end else begin
               it = sb.pop_front();
               chk("commit_cycle", k, it.commit_k);
               chk("busy_len", busy_cnt, BW + 1);
               ovf_m    = it.ovf;
               new_disp = it.val;
               have_new = 1'b1;
            end
            busy_cnt = 0;
         end
         chk("ovf", ovf, ovf_m);
         idx     = ((k - 1) / S) % N;
         dig     = (disp_m / p10(idx)) % 10;
         blanked = blank_e && (idx > 0) && (disp_m < p10(idx));
         esel    = '1;
         if (!blanked) esel[idx] = 1'b0;
         chk("BCDout", BCDout, dig);
         chk("digitSel", digitSel, esel);
         if (have_new) disp_m = new_disp;
         busy_prev = busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_until(input int target);
      while (k + 1 < target) tick();
   endtask

   // Drive load for one edge; the model decides whether it is accepted
   task automatic do_load(input int v);
      exp_t e;
      int   a;
      binIn = BW'(v);
      load  = 1'b1;
      a     = k + 1;
      if (a >= next_ok) begin
         e.val      = (v > p10(N) - 1) ? p10(N) - 1 : v;
         e.ovf      = (v > p10(N) - 1);
         e.commit_k = a + BW + 1;
         sb.push_back(e);
         next_ok    = a + BW + 2;
      end
      tick();
      load = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst     = 1'b0;
      next_ok = 0;
   endtask

   initial begin
      do_reset(3);
      idle(20);

      blankEn = 1'b0;
      do_load(1234);
      idle(BW + 22);

      blankEn = 1'b1;
      do_load(7);
      idle(BW + 22);
      do_load(0);
      idle(BW + 22);
      do_load(9005);
      idle(BW + 22);

      do_load(12000);
      idle(BW + 22);
      do_load(42);
      idle(BW + 22);

      // Loads while busy and at the commit edge are dropped
      blankEn = 1'b0;
      do_load(1111);
      for (int i = 0; i < 3; i++) do_load(2222);
      wait_until(next_ok - 1);
      do_load(3333);
      do_load(4444);
      idle(BW + 22);

      // Reset aborts a conversion in flight
      do_load(8888);
      idle(5);
      do_reset(1);
      idle(3);
      do_load(8888);
      idle(BW + 22);

      for (int i = 0; i < 40; i++) begin
         blankEn = 1'($urandom_range(0, 1));
         do_load(int'($urandom_range(0, 16383)));
         idle(int'($urandom_range(0, 30)));
         if ($urandom_range(0, 3) == 0) blankEn = ~blankEn;
         idle(int'($urandom_range(0, 10)));
      end

      idle(BW + 30);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
